pool_engine: RTL
================

Name: pool_engine

Overview:
- 2x2 stride-2 max-pool sequencer for the CNN accelerator.
- Reads conv outputs from feat_buf_pool as two-wide words (two x-adjacent pixels), one for the up row and one for the down row. Reduces each 2x2 window to one value and writes it into feat_buf_conv for the next conv layer.
- Active in top-level states POOL1 (4'b0011), POOL2 (4'b0101) and POOL3 (4'b0111). Started and acknowledged by the top-level controller.

Parameters:
- DATSIZE, 22, feature word width (signed fixed point, FPSHIFT 14).

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- state  in  4  top-level layer state; must stay constant from start until done.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the last output word has been written.
- pool_read_en  out  1  read strobe to feat_buf_pool.
- pool_read_y, pool_read_x, pool_read_c  out  6 each  pooled output coordinates.
- pool_read_updown  out  1  0 = up row (2y), 1 = down row (2y+1).
- pool_read_data  in  2*DATSIZE  [DATSIZE-1:0] = column 2x, [2*DATSIZE-1:DATSIZE] = column 2x+1; valid 1 cycle after the strobe.
- conv_write_en  out  1  write strobe to feat_buf_conv.
- conv_write_y, conv_write_x, conv_write_c  out  6 each  output coordinates.
- conv_write_data  out  DATSIZE  pooled value.

Behaviour:
- Output dimensions (H, W, C) by state:
  - POOL1: 16, 16, 16.
  - POOL2: 8, 8, 32.
  - POOL3: 4, 4, 64.
- Reset: every output is 0, FSM goes to IDLE, counters are 0. Reset mid-run aborts in the next cycle; no done pulse.
- FSM has four states: IDLE, RUN, DRAIN, FIN.
  - IDLE -> RUN: on start=1 while state is a POOL encoding. start with any other state is ignored and busy stays 0.
  - RUN:
    - Even phase: pool_read_en=1, updown=0.
    - Odd phase: pool_read_en=1, updown=1, then counters advance.
    - Counter order: x innermost, then y, then c. Counters wrap at W, H, C.
    - After the odd phase of (H-1, W-1, C-1) -> DRAIN.
  - DRAIN: wait until the last write has been issued -> FIN.
  - FIN: done=1 for one cycle -> IDLE.
- Abort: if state changes during RUN or DRAIN, go to IDLE next cycle with busy=0 and no done; an in-flight write is dropped.
- Datapath (signed compare on all values):
  - Cycle t+1 (up data arrives): hold max(up[lo], up[hi]).
  - Cycle t+2 (down data arrives): compute max(held, down[lo], down[hi]).
  - Write outputs are registered. conv_write_en is high in cycle t+3, where t is the cycle the up read was issued. Coordinates are delayed to match.
- Throughput and latency:
  - One output every 2 cycles, no bubbles between pixels or channels.
  - Total run time from start accepted to done = 2*H*W*C + 4 cycles.
- Ties: equal values yield that value; no priority issue.
- Outputs when not active: pool_read_* and conv_write_* are 0 when not in RUN or in an active write cycle.

Optional Feature:
- Macro: POOL_RELU_EN.
- Defined: the pooled value is clamped to 0 when negative before the write register (fused ReLU). No latency change.
- Undefined: raw signed max is written.

Decomposition:
- nn_pkg holds:
  - DATSIZE, PARSIZE, FPSHIFT.
  - State encodings: READ=0001, CONV1=0010, POOL1=0011, CONV2=0100, POOL2=0101, CONV3=0110, POOL3=0111.
  - Per-state pool dimension constants.
- One sub-module: pool_max4. Registered signed 2-stage max reduction, DATSIZE-generic, containing the POOL_RELU_EN clamp.

Test Plan:
- POOL1 full run, buffer filled with value = c*1024 + y*32 + x:
  - each write equals the value at (2y+1, 2x+1);
  - 4096 writes;
  - done exactly 8196 cycles after start.
- Window {-5, -3, -7, -2} (stored as 22-bit two's complement):
  - written value = -2;
  - with POOL_RELU_EN defined, written value = 0.
- POOL3 run: writes cover y, x in 0..3 and c in 0..63, in order c outer, x inner; done after 2052 cycles.
- Start with state = CONV2 (4'b0100): no reads or writes, busy stays 0, no done.
- Reset asserted mid-run at pixel 100: next cycle all outputs 0 and FSM in IDLE. A fresh start runs a complete, correct pass.
- Abort by changing state from POOL2 to CONV3 mid-run: FSM returns to IDLE, no done, no write after the abort cycle +1.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared CNN accelerator constants: word widths, top-level layer state codes, pool geometry.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package nn_pkg;

    localparam int DATSIZE = 22;   // feature word width
    localparam int PARSIZE = 16;   // weight/parameter word width
    localparam int FPSHIFT = 14;   // fixed-point fraction bits

    // Top-level layer state encodings
    localparam logic [3:0] ST_READ  = 4'b0001;
    localparam logic [3:0] ST_CONV1 = 4'b0010;
    localparam logic [3:0] ST_POOL1 = 4'b0011;
    localparam logic [3:0] ST_CONV2 = 4'b0100;
    localparam logic [3:0] ST_POOL2 = 4'b0101;
    localparam logic [3:0] ST_CONV3 = 4'b0110;
    localparam logic [3:0] ST_POOL3 = 4'b0111;

    // Pooled output geometry per pool layer
    localparam int POOL1_H = 16, POOL1_W = 16, POOL1_C = 16;
    localparam int POOL2_H = 8,  POOL2_W = 8,  POOL2_C = 32;
    localparam int POOL3_H = 4,  POOL3_W = 4,  POOL3_C = 64;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_RUN   = 2'd1,
        P_DRAIN = 2'd2,
        P_FIN   = 2'd3
    } pool_fsm_t;

    // Last index of each counter, so wrap tests are a plain equality
    typedef struct packed {
        logic [5:0] c_last;
        logic [5:0] y_last;
        logic [5:0] x_last;
    } pool_dims_t;

    function automatic logic is_pool_state(input logic [3:0] st);
        return (st == ST_POOL1) || (st == ST_POOL2) || (st == ST_POOL3);
    endfunction

    function automatic pool_dims_t pool_dims(input logic [3:0] st);
        pool_dims_t d;
        d = '0;
        case (st)
            ST_POOL1: begin
                d.c_last = 6'(POOL1_C - 1);
                d.y_last = 6'(POOL1_H - 1);
                d.x_last = 6'(POOL1_W - 1);
            end
            ST_POOL2: begin
                d.c_last = 6'(POOL2_C - 1);
                d.y_last = 6'(POOL2_H - 1);
                d.x_last = 6'(POOL2_W - 1);
            end
            ST_POOL3: begin
                d.c_last = 6'(POOL3_C - 1);
                d.y_last = 6'(POOL3_H - 1);
                d.x_last = 6'(POOL3_W - 1);
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pool_engine_if.sv
// Bundle of controller handshake, pool-buffer read port and conv-buffer write port.
// Latency: n/a (wiring only); read data returns one cycle after the strobe.
// Backpressure: none; both buffers accept a strobe every cycle.
interface pool_engine_if #(
    parameter int DATSIZE = nn_pkg::DATSIZE
);
    logic [3:0]           state;
    logic                 start;
    logic                 busy;
    logic                 done;

    logic                 pool_read_en;
    logic [5:0]           pool_read_y;
    logic [5:0]           pool_read_x;
    logic [5:0]           pool_read_c;
    logic                 pool_read_updown;
    logic [2*DATSIZE-1:0] pool_read_data;

    logic                 conv_write_en;
    logic [5:0]           conv_write_y;
    logic [5:0]           conv_write_x;
    logic [5:0]           conv_write_c;
    logic [DATSIZE-1:0]   conv_write_data;

    // The pool engine side
    modport master (
        input  state, start, pool_read_data,
        output busy, done,
        output pool_read_en, pool_read_y, pool_read_x, pool_read_c, pool_read_updown,
        output conv_write_en, conv_write_y, conv_write_x, conv_write_c, conv_write_data
    );

    // Controller plus buffers side
    modport slave (
        output state, start, pool_read_data,
        input  busy, done,
        input  pool_read_en, pool_read_y, pool_read_x, pool_read_c, pool_read_updown,
        input  conv_write_en, conv_write_y, conv_write_x, conv_write_c, conv_write_data
    );

endinterface

// File: rtl/pool_max4.sv
// Two-stage signed max of a 2x2 window delivered as an up pair then a down pair; POOL_RELU_EN adds a zero clamp.
// Latency: up pair held on cap_up, result registered on cap_dn (out valid the cycle after cap_dn).
// Backpressure: none; accepts a new window every two cycles, kill zeroes the output register.
module pool_max4 #(
    parameter int DATSIZE = 22
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kill,
    input  logic                 cap_up,
    input  logic                 cap_dn,
    input  logic [2*DATSIZE-1:0] din,
    output logic [DATSIZE-1:0]   max_q
);

    logic signed [DATSIZE-1:0] lo;
    logic signed [DATSIZE-1:0] hi;
    logic signed [DATSIZE-1:0] pair_max;
    logic signed [DATSIZE-1:0] hold;
    logic signed [DATSIZE-1:0] max3;
    logic signed [DATSIZE-1:0] result;

    assign lo       = din[DATSIZE-1:0];
    assign hi       = din[2*DATSIZE-1:DATSIZE];
    assign pair_max = (hi > lo) ? hi : lo;
    assign max3     = (hold > pair_max) ? hold : pair_max;

`ifdef POOL_RELU_EN
    // Fused ReLU: negative window maxima become zero
    assign result = max3[DATSIZE-1] ? '0 : max3;
`else
    assign result = max3;
`endif

    // Stage 1: keep the larger of the two up-row pixels
    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
        end else if (cap_up) begin
            hold <= pair_max;
        end
    end

    // Stage 2: final max becomes the write data; zero outside write cycles
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            max_q <= '0;
        end else if (cap_dn) begin
            max_q <= result;
        end else begin
            max_q <= '0;
        end
    end

endmodule

// File: rtl/pool_engine.sv
// 2x2 stride-2 max-pool sequencer: reads up/down row pairs, writes one pooled word per two cycles (POOL_RELU_EN selects fused ReLU).
// Latency: write 3 cycles after its up-row read; done 2*H*W*C+4 cycles after start is accepted.
// Backpressure: none; any change of the layer state while active aborts the pass without done.
module pool_engine
    import nn_pkg::*;
#(
    parameter int DATSIZE = nn_pkg::DATSIZE
) (
    input  logic          clk,
    input  logic          rst,
    pool_engine_if.master bus
);

    pool_fsm_t          fsm;
    logic [3:0]         run_state;
    pool_dims_t         dims;

    logic               rd_en;
    logic               rd_updown;
    logic [5:0]         rd_y;
    logic [5:0]         rd_x;
    logic [5:0]         rd_c;
    logic               busy_q;
    logic               done_q;

    logic               cap_up;
    logic               cap_dn;
    logic [5:0]         pend_y;
    logic [5:0]         pend_x;
    logic [5:0]         pend_c;
    logic               wr_en;
    logic [5:0]         wr_y;
    logic [5:0]         wr_x;
    logic [5:0]         wr_c;
    logic [DATSIZE-1:0] wr_data;

    logic               active;
    logic               abort;
    logic               last_pix;
    logic               pipe_empty;

    assign active     = (fsm == P_RUN) || (fsm == P_DRAIN);
    assign abort      = active && (bus.state != run_state);
    assign last_pix   = (rd_c == dims.c_last) && (rd_y == dims.y_last) && (rd_x == dims.x_last);
    assign pipe_empty = !cap_up && !cap_dn && !wr_en;

    // Sequencer: issues up/down reads, walks x then y then c, then drains and pulses done
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= P_IDLE;
            run_state <= '0;
            dims      <= '0;
            rd_en     <= 1'b0;
            rd_updown <= 1'b0;
            rd_y      <= '0;
            rd_x      <= '0;
            rd_c      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm)
                P_IDLE: begin
                    if (bus.start && is_pool_state(bus.state)) begin
                        fsm       <= P_RUN;
                        run_state <= bus.state;
                        dims      <= pool_dims(bus.state);
                        busy_q    <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_updown <= 1'b0;
                        rd_y      <= '0;
                        rd_x      <= '0;
                        rd_c      <= '0;
                    end
                end
                P_RUN: begin
                    if (abort) begin
                        fsm       <= P_IDLE;
                        busy_q    <= 1'b0;
                        rd_en     <= 1'b0;
                        rd_updown <= 1'b0;
                        rd_y      <= '0;
                        rd_x      <= '0;
                        rd_c      <= '0;
                    end else if (!rd_updown) begin
                        rd_updown <= 1'b1;
                    end else begin
                        rd_updown <= 1'b0;
                        if (last_pix) begin
                            fsm   <= P_DRAIN;
                            rd_en <= 1'b0;
                            rd_y  <= '0;
                            rd_x  <= '0;
                            rd_c  <= '0;
                        end else if (rd_x != dims.x_last) begin
                            rd_x <= rd_x + 6'd1;
                        end else begin
                            rd_x <= '0;
                            if (rd_y != dims.y_last) begin
                                rd_y <= rd_y + 6'd1;
                            end else begin
                                rd_y <= '0;
                                rd_c <= rd_c + 6'd1;
                            end
                        end
                    end
                end
                P_DRAIN: begin
                    // Leave only once the final write has gone out
                    if (abort) begin
                        fsm    <= P_IDLE;
                        busy_q <= 1'b0;
                    end else if (pipe_empty) begin
                        fsm    <= P_FIN;
                        done_q <= 1'b1;
                    end
                end
                P_FIN: begin
                    fsm    <= P_IDLE;
                    busy_q <= 1'b0;
                end
                default: fsm <= P_IDLE;
            endcase
        end
    end

    // Write-side pipeline: track which read returns data and carry coordinates to the write
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            cap_up <= 1'b0;
            cap_dn <= 1'b0;
            pend_y <= '0;
            pend_x <= '0;
            pend_c <= '0;
            wr_en  <= 1'b0;
            wr_y   <= '0;
            wr_x   <= '0;
            wr_c   <= '0;
        end else begin
            cap_up <= rd_en && !rd_updown;
            cap_dn <= rd_en && rd_updown;
            if (rd_en && rd_updown) begin
                pend_y <= rd_y;
                pend_x <= rd_x;
                pend_c <= rd_c;
            end
            wr_en <= cap_dn;
            wr_y  <= cap_dn ? pend_y : '0;
            wr_x  <= cap_dn ? pend_x : '0;
            wr_c  <= cap_dn ? pend_c : '0;
        end
    end

    pool_max4 #(
        .DATSIZE (DATSIZE)
    ) u_max4 (
        .clk    (clk),
        .rst    (rst),
        .kill   (abort),
        .cap_up (cap_up),
        .cap_dn (cap_dn),
        .din    (bus.pool_read_data),
        .max_q  (wr_data)
    );

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pool_read_en     = rd_en;
    assign bus.pool_read_updown = rd_updown;
    assign bus.pool_read_y      = rd_y;
    assign bus.pool_read_x      = rd_x;
    assign bus.pool_read_c      = rd_c;
    assign bus.conv_write_en    = wr_en;
    assign bus.conv_write_y     = wr_y;
    assign bus.conv_write_x     = wr_x;
    assign bus.conv_write_c     = wr_c;
    assign bus.conv_write_data  = wr_data;

endmodule
